plot_arbiter: RTL and testbench
===============================

Name: plot_arbiter

Overview:
- Shares the single rectangle plotter between the three object engines: ball, paddle and brick.
- Each engine raises a request carrying old/new position and size. The arbiter grants requesters round-robin, then sequences the plotter: erase the old rectangle in background colour, then draw the new rectangle in the object colour.
- Sits between the game-logic engines and the VGA plotter. It replaces the free-running startPlot/object mux with an explicit handshake.

Parameters:
- BG_COLOUR, 3'b000, erase colour.
- BALL_COLOUR, 3'b111, draw colour for requester 0.
- PADDLE_COLOUR, 3'b010, draw colour for requester 1.
- BRICK_COLOUR, 3'b100, draw colour for requester 2.
- PLOT_TIMEOUT, 20000, max cycles to wait for plot_done (optional feature only).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  3  per-requester request level; [0]=ball, [1]=paddle, [2]=brick
- ack  out  3  one-cycle pulse: request i captured
- new_x_bus  in  24  3x8b new X, requester i at [8i+7:8i]
- new_y_bus  in  21  3x7b new Y
- old_x_bus  in  24  3x8b old X
- old_y_bus  in  21  3x7b old Y
- size_x_bus  in  24  3x8b width
- size_y_bus  in  21  3x7b height
- erase_only  in  3  per-requester: skip the draw phase (brick deletion)
- plot_x  out  8  plotter rectangle X
- plot_y  out  7  plotter rectangle Y
- plot_w  out  8  plotter width
- plot_h  out  7  plotter height
- plot_colour  out  3  plotter colour
- plot_start  out  1  one-cycle plotter start pulse
- plot_done  in  1  plotter completion pulse
- object  out  2  granted requester id (00 ball, 01 paddle, 10 brick, 11 none)
- busy  out  1  high in every state except IDLE
- xfer_done  out  1  one-cycle pulse when a transaction ends

Behaviour:
- Reset values:
  - state=IDLE, rr_ptr=0.
  - ack=0, plot_start=0, xfer_done=0, busy=0.
  - plot_x/y/w/h=0, plot_colour=BG_COLOUR, object=2'b11.
- States: IDLE, ERASE, ERASE_WAIT, DRAW, DRAW_WAIT, FINISH.
- IDLE, arbitration:
  - The first set req bit, searching from rr_ptr upward mod 3, wins.
  - On the winning cycle N: capture that requester's bundle into internal registers.
  - Cycle N+1: ack[i] pulses for one cycle; object=i; rr_ptr <= (i+1) mod 3.
- Zero size: if the captured width==0 or height==0, go straight to FINISH. No plot_start is issued.
- Unchanged position: if old==new in both X and Y and erase_only=0, skip ERASE and go to DRAW.
- ERASE:
  - Drive old_x/old_y, the size and BG_COLOUR.
  - plot_start=1 for exactly one cycle (cycle N+1 on the normal path), then go to ERASE_WAIT.
- ERASE_WAIT:
  - Hold all plot_* outputs.
  - On plot_done: go to FINISH if erase_only, else to DRAW.
- DRAW:
  - Drive new_x/new_y, the size and the object colour.
  - plot_start pulses one cycle, then go to DRAW_WAIT.
- DRAW_WAIT: on plot_done, go to FINISH.
- FINISH: xfer_done=1 for one cycle; object=2'b11; return to IDLE. The next grant is possible the cycle after.
- plot_done is ignored outside the two WAIT states, including a done in the same cycle as plot_start.
- req is sampled only in IDLE. Bundle inputs may change after ack without effect.
- A req dropped before capture is lost; no latching.
- Simultaneous requests are served round-robin, so no requester starves: with all three held high, the order is 0,1,2,0,…
- Reset mid-transaction: back to IDLE at the next edge. plot_start is low the cycle after reset. The aborted requester must re-request.
- No arithmetic is performed; widths pass through unchanged.

Optional Feature:
- Macro PLOT_TIMEOUT_EN.
- When defined:
  - A 16-bit counter runs in both WAIT states.
  - Reaching PLOT_TIMEOUT without plot_done forces FINISH and pulses output timeout_err (1 bit, reset 0) for one cycle alongside xfer_done.
- When undefined: the WAIT states wait forever, and the timeout_err port and the counter do not exist.

Decomposition:
- Package plot_pkg holds:
  - object id constants (OBJ_BALL, OBJ_PADDLE, OBJ_BRICK, OBJ_NONE);
  - the state encoding;
  - the colour defaults.
- One sub-module, rr_pick3: combinational round-robin priority picker, taking req and rr_ptr and returning grant index plus valid.

Test Plan:
- Single ball request: req=001, old=(50,100), new=(51,99), size 4x4, done 10 cycles after each start.
  - ack[0] one cycle after req.
  - ERASE plot at (50,100) colour 000, then DRAW at (51,99) colour 111.
  - xfer_done once.
- Brick erase_only: req=100, old=(32,10), size 16x10.
  - Exactly one plot_start with colour 000.
  - No draw phase; object=10 during the transaction.
- Contention: req=111 held, plotter auto-done.
  - Grants in order 0,1,2,0.
  - Each ack exactly one cycle.
  - No overlapping plot_start.
- Zero size and unchanged position:
  - Width 0 gives ack and xfer_done with no plot_start.
  - old==new gives a single draw plot_start.
- Reset in DRAW_WAIT: busy and object=11 after the edge; later plot_done is ignored; a new req is served normally.
- PLOT_TIMEOUT_EN with PLOT_TIMEOUT=100 and plot_done never asserted: timeout_err and xfer_done pulse 100 cycles after plot_start.

Source files
------------

// File: rtl/plot_arbiter_pkg.sv
// ============================================================================
// Package     : plot_pkg
// Description : Shared definitions for the plot arbiter. Holds the object id
//               codes, the sequencer state encoding, the colour defaults and
//               a modulo-3 increment helper.
//               Optional macro PLOT_TIMEOUT_EN adds the default plot timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package plot_pkg;

  // Object ids as seen on the 'object' output
  localparam logic [1:0] OBJ_BALL   = 2'd0;
  localparam logic [1:0] OBJ_PADDLE = 2'd1;
  localparam logic [1:0] OBJ_BRICK  = 2'd2;
  localparam logic [1:0] OBJ_NONE   = 2'd3;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ERASE      = 3'd1,
    ST_ERASE_WAIT = 3'd2,
    ST_DRAW       = 3'd3,
    ST_DRAW_WAIT  = 3'd4,
    ST_FINISH     = 3'd5
  } state_t;

  // Colour defaults
  localparam logic [2:0] DEF_BG_COLOUR     = 3'b000;
  localparam logic [2:0] DEF_BALL_COLOUR   = 3'b111;
  localparam logic [2:0] DEF_PADDLE_COLOUR = 3'b010;
  localparam logic [2:0] DEF_BRICK_COLOUR  = 3'b100;

`ifdef PLOT_TIMEOUT_EN
  localparam int DEF_PLOT_TIMEOUT = 20000;
`endif

  // (a + 1) mod 3 for requester ids 0..2
  function automatic logic [1:0] inc3(input logic [1:0] a);
    return (a >= 2'd2) ? 2'd0 : a + 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/plot_arbiter_if.sv
// ============================================================================
// Interface   : plot_arbiter_if
// Description : Engine-request and plotter-command bundle of the plot arbiter.
//               slave  : arbiter view (requests/plot_done in, commands out)
//               master : environment view (engines + plotter)
//               Optional macro PLOT_TIMEOUT_EN adds timeout_err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface plot_arbiter_if;

  logic [2:0]  req;          // per-requester request level
  logic [2:0]  ack;          // one-cycle capture pulse
  logic [23:0] new_x_bus;    // 3 x 8b new X
  logic [20:0] new_y_bus;    // 3 x 7b new Y
  logic [23:0] old_x_bus;    // 3 x 8b old X
  logic [20:0] old_y_bus;    // 3 x 7b old Y
  logic [23:0] size_x_bus;   // 3 x 8b width
  logic [20:0] size_y_bus;   // 3 x 7b height
  logic [2:0]  erase_only;   // per-requester: skip draw phase
  logic [7:0]  plot_x;
  logic [6:0]  plot_y;
  logic [7:0]  plot_w;
  logic [6:0]  plot_h;
  logic [2:0]  plot_colour;
  logic        plot_start;
  logic        plot_done;
  logic [1:0]  object;
  logic        busy;
  logic        xfer_done;
`ifdef PLOT_TIMEOUT_EN
  logic        timeout_err;
`endif

`ifdef PLOT_TIMEOUT_EN
  modport slave (
    input  req, new_x_bus, new_y_bus, old_x_bus, old_y_bus,
           size_x_bus, size_y_bus, erase_only, plot_done,
    output ack, plot_x, plot_y, plot_w, plot_h, plot_colour, plot_start,
           object, busy, xfer_done, timeout_err
  );
  modport master (
    output req, new_x_bus, new_y_bus, old_x_bus, old_y_bus,
           size_x_bus, size_y_bus, erase_only, plot_done,
    input  ack, plot_x, plot_y, plot_w, plot_h, plot_colour, plot_start,
           object, busy, xfer_done, timeout_err
  );
`else
  modport slave (
    input  req, new_x_bus, new_y_bus, old_x_bus, old_y_bus,
           size_x_bus, size_y_bus, erase_only, plot_done,
    output ack, plot_x, plot_y, plot_w, plot_h, plot_colour, plot_start,
           object, busy, xfer_done
  );
  modport master (
    output req, new_x_bus, new_y_bus, old_x_bus, old_y_bus,
           size_x_bus, size_y_bus, erase_only, plot_done,
    input  ack, plot_x, plot_y, plot_w, plot_h, plot_colour, plot_start,
           object, busy, xfer_done
  );
`endif

endinterface

`default_nettype wire

// File: rtl/plot_arbiter_rr_pick3.sv
// ============================================================================
// Module      : rr_pick3
// Description : Combinational round-robin picker for three requesters. The
//               first set request bit searching upward (mod 3) from the
//               pointer wins.
// Ports       : i_req[2:0]  request levels
//               i_rr_ptr    highest-priority requester this cycle (0..2)
//               o_idx       winning requester id
//               o_valid     at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick3
  import plot_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic [1:0] i_rr_ptr,
  output logic [1:0] o_idx,
  output logic       o_valid
);

  logic [1:0] w_order [3];

  always_comb begin
    w_order[0] = i_rr_ptr;
    w_order[1] = inc3(i_rr_ptr);
    w_order[2] = inc3(inc3(i_rr_ptr));
    o_valid    = 1'b0;
    o_idx      = OBJ_BALL;
    // Scan lowest priority first so the highest-priority hit is written last
    for (int k = 2; k >= 0; k--) begin
      if (i_req[w_order[k]]) begin
        o_valid = 1'b1;
        o_idx   = w_order[k];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/plot_arbiter.sv
// ============================================================================
// Module      : plot_arbiter
// Description : Shares one rectangle plotter between the ball, paddle and
//               brick engines. Grants round-robin, then erases the old
//               rectangle in background colour and draws the new one in the
//               object colour.
// Ports       : clk, reset (synchronous, active high)
//               bus : plot_arbiter_if.slave (requests, bundles, plot cmds)
// Optional    : PLOT_TIMEOUT_EN - abort a WAIT state after PLOT_TIMEOUT
//               cycles without plot_done and pulse timeout_err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module plot_arbiter
  import plot_pkg::*;
#(
  parameter logic [2:0] BG_COLOUR     = DEF_BG_COLOUR,
  parameter logic [2:0] BALL_COLOUR   = DEF_BALL_COLOUR,
  parameter logic [2:0] PADDLE_COLOUR = DEF_PADDLE_COLOUR,
  parameter logic [2:0] BRICK_COLOUR  = DEF_BRICK_COLOUR
`ifdef PLOT_TIMEOUT_EN
  , parameter int PLOT_TIMEOUT = DEF_PLOT_TIMEOUT
`endif
) (
  input  wire logic     clk,
  input  wire logic     reset,
  plot_arbiter_if.slave bus
);

  state_t     r_state, w_state_next;
  logic [1:0] r_rr_ptr, w_rr_ptr_next;

  // Captured request bundle (old position is consumed at grant time)
  logic [7:0] r_cap_new_x, w_cap_new_x;
  logic [6:0] r_cap_new_y, w_cap_new_y;
  logic       r_cap_erase, w_cap_erase;
  logic [1:0] r_cap_id,    w_cap_id;

  // Registered outputs
  logic [2:0] r_ack,        w_ack_next;
  logic [7:0] r_plot_x,     w_plot_x_next;
  logic [6:0] r_plot_y,     w_plot_y_next;
  logic [7:0] r_plot_w,     w_plot_w_next;
  logic [6:0] r_plot_h,     w_plot_h_next;
  logic [2:0] r_plot_col,   w_plot_col_next;
  logic       r_plot_start, w_plot_start_next;
  logic [1:0] r_object,     w_object_next;
  logic       r_xfer_done,  w_xfer_done_next;

  logic [1:0] w_pick_idx;
  logic       w_pick_valid;
  logic [7:0] w_sel_new_x, w_sel_old_x, w_sel_w;
  logic [6:0] w_sel_new_y, w_sel_old_y, w_sel_h;

`ifdef PLOT_TIMEOUT_EN
  logic [15:0] r_tmo_cnt, w_tmo_cnt_next;
  logic        r_timeout_err, w_timeout_err_next;
  logic        w_tmo_hit;
`endif

  rr_pick3 u_pick (
    .i_req    (bus.req),
    .i_rr_ptr (r_rr_ptr),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  function automatic logic [2:0] obj_colour(input logic [1:0] id);
    case (id)
      OBJ_BALL:   return BALL_COLOUR;
      OBJ_PADDLE: return PADDLE_COLOUR;
      default:    return BRICK_COLOUR;
    endcase
  endfunction

  assign w_sel_new_x = bus.new_x_bus [8*w_pick_idx +: 8];
  assign w_sel_old_x = bus.old_x_bus [8*w_pick_idx +: 8];
  assign w_sel_w     = bus.size_x_bus[8*w_pick_idx +: 8];
  assign w_sel_new_y = bus.new_y_bus [7*w_pick_idx +: 7];
  assign w_sel_old_y = bus.old_y_bus [7*w_pick_idx +: 7];
  assign w_sel_h     = bus.size_y_bus[7*w_pick_idx +: 7];

`ifdef PLOT_TIMEOUT_EN
  // Counter holds cycles since plot_start; FINISH is reached exactly
  // PLOT_TIMEOUT cycles after the start pulse.
  assign w_tmo_hit = (r_tmo_cnt == 16'(PLOT_TIMEOUT - 1));

  always_comb begin
    w_tmo_cnt_next = 16'd0;
    case (r_state)
      ST_ERASE, ST_DRAW:           w_tmo_cnt_next = 16'd1;
      ST_ERASE_WAIT, ST_DRAW_WAIT: w_tmo_cnt_next = r_tmo_cnt + 16'd1;
      default:                     w_tmo_cnt_next = 16'd0;
    endcase
  end
`endif

  always_comb begin
    w_state_next      = r_state;
    w_rr_ptr_next     = r_rr_ptr;
    w_cap_new_x       = r_cap_new_x;
    w_cap_new_y       = r_cap_new_y;
    w_cap_erase       = r_cap_erase;
    w_cap_id          = r_cap_id;
    w_ack_next        = 3'b000;
    w_plot_x_next     = r_plot_x;
    w_plot_y_next     = r_plot_y;
    w_plot_w_next     = r_plot_w;
    w_plot_h_next     = r_plot_h;
    w_plot_col_next   = r_plot_col;
    w_plot_start_next = 1'b0;
    w_object_next     = r_object;
    w_xfer_done_next  = 1'b0;
`ifdef PLOT_TIMEOUT_EN
    w_timeout_err_next = 1'b0;
`endif

    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_cap_new_x   = w_sel_new_x;
          w_cap_new_y   = w_sel_new_y;
          w_cap_erase   = bus.erase_only[w_pick_idx];
          w_cap_id      = w_pick_idx;
          w_ack_next    = 3'b001 << w_pick_idx;
          w_object_next = w_pick_idx;
          w_rr_ptr_next = inc3(w_pick_idx);
          w_plot_w_next = w_sel_w;
          w_plot_h_next = w_sel_h;
          if (w_sel_w == 8'd0 || w_sel_h == 7'd0) begin
            // Nothing to plot; the ack cycle doubles as the FINISH cycle
            w_state_next     = ST_FINISH;
            w_xfer_done_next = 1'b1;
          end else if (w_sel_old_x == w_sel_new_x && w_sel_old_y == w_sel_new_y
                       && !bus.erase_only[w_pick_idx]) begin
            w_state_next      = ST_DRAW;
            w_plot_x_next     = w_sel_new_x;
            w_plot_y_next     = w_sel_new_y;
            w_plot_col_next   = obj_colour(w_pick_idx);
            w_plot_start_next = 1'b1;
          end else begin
            w_state_next      = ST_ERASE;
            w_plot_x_next     = w_sel_old_x;
            w_plot_y_next     = w_sel_old_y;
            w_plot_col_next   = BG_COLOUR;
            w_plot_start_next = 1'b1;
          end
        end
      end
      ST_ERASE: w_state_next = ST_ERASE_WAIT;
      ST_ERASE_WAIT: begin
        if (bus.plot_done) begin
          if (r_cap_erase) begin
            w_state_next     = ST_FINISH;
            w_xfer_done_next = 1'b1;
            w_object_next    = OBJ_NONE;
          end else begin
            w_state_next      = ST_DRAW;
            w_plot_x_next     = r_cap_new_x;
            w_plot_y_next     = r_cap_new_y;
            w_plot_col_next   = obj_colour(r_cap_id);
            w_plot_start_next = 1'b1;
          end
        end
`ifdef PLOT_TIMEOUT_EN
        else if (w_tmo_hit) begin
          w_state_next       = ST_FINISH;
          w_xfer_done_next   = 1'b1;
          w_timeout_err_next = 1'b1;
          w_object_next      = OBJ_NONE;
        end
`endif
      end
      ST_DRAW: w_state_next = ST_DRAW_WAIT;
      ST_DRAW_WAIT: begin
        if (bus.plot_done) begin
          w_state_next     = ST_FINISH;
          w_xfer_done_next = 1'b1;
          w_object_next    = OBJ_NONE;
        end
`ifdef PLOT_TIMEOUT_EN
        else if (w_tmo_hit) begin
          w_state_next       = ST_FINISH;
          w_xfer_done_next   = 1'b1;
          w_timeout_err_next = 1'b1;
          w_object_next      = OBJ_NONE;
        end
`endif
      end
      ST_FINISH: begin
        w_state_next  = ST_IDLE;
        w_object_next = OBJ_NONE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= 2'd0;
      r_cap_new_x  <= 8'd0;
      r_cap_new_y  <= 7'd0;
      r_cap_erase  <= 1'b0;
      r_cap_id     <= OBJ_BALL;
      r_ack        <= 3'b000;
      r_plot_x     <= 8'd0;
      r_plot_y     <= 7'd0;
      r_plot_w     <= 8'd0;
      r_plot_h     <= 7'd0;
      r_plot_col   <= BG_COLOUR;
      r_plot_start <= 1'b0;
      r_object     <= OBJ_NONE;
      r_xfer_done  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_rr_ptr     <= w_rr_ptr_next;
      r_cap_new_x  <= w_cap_new_x;
      r_cap_new_y  <= w_cap_new_y;
      r_cap_erase  <= w_cap_erase;
      r_cap_id     <= w_cap_id;
      r_ack        <= w_ack_next;
      r_plot_x     <= w_plot_x_next;
      r_plot_y     <= w_plot_y_next;
      r_plot_w     <= w_plot_w_next;
      r_plot_h     <= w_plot_h_next;
      r_plot_col   <= w_plot_col_next;
      r_plot_start <= w_plot_start_next;
      r_object     <= w_object_next;
      r_xfer_done  <= w_xfer_done_next;
    end
  end

`ifdef PLOT_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo_cnt     <= 16'd0;
      r_timeout_err <= 1'b0;
    end else begin
      r_tmo_cnt     <= w_tmo_cnt_next;
      r_timeout_err <= w_timeout_err_next;
    end
  end
  assign bus.timeout_err = r_timeout_err;
`endif

  assign bus.ack         = r_ack;
  assign bus.plot_x      = r_plot_x;
  assign bus.plot_y      = r_plot_y;
  assign bus.plot_w      = r_plot_w;
  assign bus.plot_h      = r_plot_h;
  assign bus.plot_colour = r_plot_col;
  assign bus.plot_start  = r_plot_start;
  assign bus.object      = r_object;
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.xfer_done   = r_xfer_done;

endmodule

`default_nettype wire

// File: tb/tb_plot_arbiter.sv
// ============================================================================
// Module      : tb_plot_arbiter
// Description : Self-checking bench for plot_arbiter. Expected plotter
//               commands are queued when a request is driven and compared as
//               plot_start pulses appear. A simple plotter model returns
//               plot_done a programmable number of cycles after each start.
//               Build with PLOT_TIMEOUT_EN to include the timeout scenario.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_plot_arbiter;
  import plot_pkg::*;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [7:0] w;
    logic [6:0] h;
    logic [2:0] c;
    logic [1:0] obj;
  } plot_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  plot_arbiter_if bus();

`ifdef PLOT_TIMEOUT_EN
  plot_arbiter #(.PLOT_TIMEOUT(100)) dut (.clk(clk), .reset(reset), .bus(bus));
`else
  plot_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  int    n_starts = 0;
  int    n_xfer   = 0;
  int    pl_cnt   = 0;
  int    done_delay = 10;  // 0 = plotter never answers
  logic [2:0] prev_ack = 3'b000;
  plot_t exp_q[$];

  always @(posedge clk) cyc++;

  // Monitor + plotter model (one process so plotter state is race-free)
  always @(negedge clk) begin
    plot_t e;
    if (bus.plot_start === 1'b1) begin
      n_starts++;
      checks++;
      if (pl_cnt != 0) begin
        failures++;
        $display("FAIL overlap_start cyc=%0d plotter still busy (cnt=%0d), required idle", cyc, pl_cnt);
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_start cyc=%0d x=%0d y=%0d col=%b, required no start",
                 cyc, bus.plot_x, bus.plot_y, bus.plot_colour);
      end else begin
        e = exp_q.pop_front();
        if ({bus.plot_x, bus.plot_y, bus.plot_w, bus.plot_h, bus.plot_colour, bus.object}
            !== {e.x, e.y, e.w, e.h, e.c, e.obj}) begin
          failures++;
          $display("FAIL plot_cmd cyc=%0d got x=%0d y=%0d w=%0d h=%0d col=%b obj=%0d, required x=%0d y=%0d w=%0d h=%0d col=%b obj=%0d",
                   cyc, bus.plot_x, bus.plot_y, bus.plot_w, bus.plot_h, bus.plot_colour, bus.object,
                   e.x, e.y, e.w, e.h, e.c, e.obj);
        end
      end
    end
    if (bus.ack !== 3'b000) begin
      checks++;
      if (prev_ack !== 3'b000) begin
        failures++;
        $display("FAIL ack_width cyc=%0d ack=%b after ack=%b, required single-cycle pulse", cyc, bus.ack, prev_ack);
      end
    end
    prev_ack = bus.ack;
    if (bus.xfer_done === 1'b1) n_xfer++;
    // plotter: done pulse done_delay cycles after start
    bus.plot_done = 1'b0;
    if (pl_cnt > 0) begin
      pl_cnt--;
      if (pl_cnt == 0) bus.plot_done = 1'b1;
    end
    if (bus.plot_start === 1'b1) pl_cnt = (done_delay == 0) ? 1000000 : done_delay;
  end

  function automatic void push_exp(input int x, y, w, h, input logic [2:0] c, input logic [1:0] o);
    plot_t e;
    e.x = x[7:0]; e.y = y[6:0]; e.w = w[7:0]; e.h = h[6:0]; e.c = c; e.obj = o;
    exp_q.push_back(e);
  endfunction

  task automatic set_bundle(input int i, ox, oy, nx, ny, w, h, input logic eo);
    bus.old_x_bus [8*i +: 8] = ox[7:0];
    bus.old_y_bus [7*i +: 7] = oy[6:0];
    bus.new_x_bus [8*i +: 8] = nx[7:0];
    bus.new_y_bus [7*i +: 7] = ny[6:0];
    bus.size_x_bus[8*i +: 8] = w[7:0];
    bus.size_y_bus[7*i +: 7] = h[6:0];
    bus.erase_only[i]        = eo;
  endtask

  task automatic wait_xfer(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.xfer_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.ack, bus.plot_start, bus.xfer_done} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl busy=%b ack=%b start=%b xfer=%b, required all 0",
               bus.busy, bus.ack, bus.plot_start, bus.xfer_done);
    end
    checks++;
    if (bus.object !== 2'b11) begin
      failures++;
      $display("FAIL reset_object got %b, required 11", bus.object);
    end
    checks++;
    if ({bus.plot_x, bus.plot_y, bus.plot_w, bus.plot_h, bus.plot_colour} !== {8'd0, 7'd0, 8'd0, 7'd0, 3'b000}) begin
      failures++;
      $display("FAIL reset_plot x=%0d y=%0d w=%0d h=%0d col=%b, required zeros col=000",
               bus.plot_x, bus.plot_y, bus.plot_w, bus.plot_h, bus.plot_colour);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_ball();
    bit ok;
    int x0 = n_xfer;
    int s0 = n_starts;
    done_delay = 10;
    set_bundle(0, 50, 100, 51, 99, 4, 4, 1'b0);
    push_exp(50, 100, 4, 4, 3'b000, 2'd0);
    push_exp(51, 99, 4, 4, 3'b111, 2'd0);
    bus.req = 3'b001;
    @(negedge clk);
    checks++;
    if ({bus.ack, bus.object, bus.plot_start} !== {3'b001, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL ball_ack ack=%b obj=%0d start=%b, required 001/0/1", bus.ack, bus.object, bus.plot_start);
    end
    bus.req = 3'b000;
    wait_xfer(100, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL ball_xfer timed out, required xfer_done"); end
    repeat (3) @(negedge clk);
    checks++;
    if (n_xfer - x0 != 1 || n_starts - s0 != 2 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL ball_counts xfers=%0d starts=%0d left=%0d, required 1/2/0", n_xfer - x0, n_starts - s0, exp_q.size());
    end
  endtask

  task automatic test_brick_erase();
    bit ok;
    int x0 = n_xfer;
    int s0 = n_starts;
    done_delay = 6;
    set_bundle(2, 32, 10, 90, 40, 16, 10, 1'b1);
    push_exp(32, 10, 16, 10, 3'b000, 2'd2);
    bus.req = 3'b100;
    @(negedge clk);
    checks++;
    if ({bus.ack, bus.object} !== {3'b100, 2'd2}) begin
      failures++;
      $display("FAIL brick_ack ack=%b obj=%0d, required 100/2", bus.ack, bus.object);
    end
    bus.req = 3'b000;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.object !== 2'd2 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL brick_mid obj=%0d busy=%b, required 2/1", bus.object, bus.busy);
    end
    wait_xfer(100, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL brick_xfer timed out, required xfer_done"); end
    repeat (3) @(negedge clk);
    checks++;
    if (n_xfer - x0 != 1 || n_starts - s0 != 1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL brick_counts xfers=%0d starts=%0d left=%0d, required 1/1/0", n_xfer - x0, n_starts - s0, exp_q.size());
    end
    bus.erase_only = 3'b000;
  endtask

  task automatic test_contention();
    bit ok;
    int got [4];
    int ng = 0;
    int want [4] = '{0, 1, 2, 0};
    done_delay = 3;
    set_bundle(0, 10, 10, 11, 11, 2, 2, 1'b0);
    set_bundle(1, 60, 110, 62, 110, 20, 4, 1'b0);
    set_bundle(2, 100, 20, 100, 21, 8, 3, 1'b0);
    push_exp(10, 10, 2, 2, 3'b000, 2'd0);   push_exp(11, 11, 2, 2, 3'b111, 2'd0);
    push_exp(60, 110, 20, 4, 3'b000, 2'd1); push_exp(62, 110, 20, 4, 3'b010, 2'd1);
    push_exp(100, 20, 8, 3, 3'b000, 2'd2);  push_exp(100, 21, 8, 3, 3'b100, 2'd2);
    push_exp(10, 10, 2, 2, 3'b000, 2'd0);   push_exp(11, 11, 2, 2, 3'b111, 2'd0);
    bus.req = 3'b111;
    for (int i = 0; i < 300 && ng < 4; i++) begin
      @(negedge clk);
      if (bus.ack !== 3'b000) begin
        got[ng] = (bus.ack === 3'b001) ? 0 : (bus.ack === 3'b010) ? 1 : (bus.ack === 3'b100) ? 2 : 9;
        ng++;
      end
    end
    bus.req = 3'b000;
    checks++;
    if (ng != 4) begin failures++; $display("FAIL rr_grants got %0d grants, required 4", ng); end
    for (int i = 0; i < ng; i++) begin
      checks++;
      if (got[i] != want[i]) begin
        failures++;
        $display("FAIL rr_order grant %0d got %0d, required %0d", i, got[i], want[i]);
      end
    end
    wait_xfer(100, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      failures++;
      $display("FAIL rr_drain ok=%b left=%0d, required 1/0", ok, exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_zero_unchanged();
    bit ok;
    int x0 = n_xfer;
    int s0 = n_starts;
    done_delay = 4;
    set_bundle(0, 5, 5, 6, 6, 0, 4, 1'b0);
    bus.req = 3'b001;
    @(negedge clk);
    checks++;
    if ({bus.ack, bus.plot_start, bus.xfer_done} !== {3'b001, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL zero_size ack=%b start=%b xfer=%b, required 001/0/1", bus.ack, bus.plot_start, bus.xfer_done);
    end
    bus.req = 3'b000;
    repeat (3) @(negedge clk);
    checks++;
    if (n_xfer - x0 != 1 || n_starts != s0) begin
      failures++;
      $display("FAIL zero_counts xfers=%0d starts=%0d, required 1/0", n_xfer - x0, n_starts - s0);
    end
    set_bundle(1, 40, 60, 40, 60, 5, 3, 1'b0);
    push_exp(40, 60, 5, 3, 3'b010, 2'd1);
    bus.req = 3'b010;
    @(negedge clk);
    checks++;
    if ({bus.ack, bus.plot_start, bus.plot_colour} !== {3'b010, 1'b1, 3'b010}) begin
      failures++;
      $display("FAIL same_pos ack=%b start=%b col=%b, required 010/1/010", bus.ack, bus.plot_start, bus.plot_colour);
    end
    bus.req = 3'b000;
    wait_xfer(100, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || n_starts - s0 != 1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL same_pos_counts ok=%b starts=%0d left=%0d, required 1/1/0", ok, n_starts - s0, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int s0 = n_starts;
    int x0;
    done_delay = 10;
    set_bundle(0, 20, 30, 25, 35, 6, 6, 1'b0);
    push_exp(20, 30, 6, 6, 3'b000, 2'd0);
    push_exp(25, 35, 6, 6, 3'b111, 2'd0);
    bus.req = 3'b001;
    @(negedge clk);
    bus.req = 3'b000;
    for (int i = 0; i < 100 && n_starts < s0 + 2; i++) @(negedge clk);
    checks++;
    if (n_starts != s0 + 2) begin failures++; $display("FAIL rst_reach_draw starts=%0d, required 2", n_starts - s0); end
    repeat (3) @(negedge clk);
    x0 = n_xfer;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({bus.busy, bus.object, bus.plot_start} !== {1'b0, 2'b11, 1'b0}) begin
      failures++;
      $display("FAIL rst_mid busy=%b obj=%b start=%b, required 0/11/0", bus.busy, bus.object, bus.plot_start);
    end
    repeat (15) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || n_xfer != x0) begin
      failures++;
      $display("FAIL rst_ignore_done busy=%b xfers=%0d, required 0/0", bus.busy, n_xfer - x0);
    end
    set_bundle(1, 70, 50, 71, 50, 3, 3, 1'b0);
    push_exp(70, 50, 3, 3, 3'b000, 2'd1);
    push_exp(71, 50, 3, 3, 3'b010, 2'd1);
    bus.req = 3'b010;
    @(negedge clk);
    checks++;
    if (bus.ack !== 3'b010) begin failures++; $display("FAIL rst_new_ack ack=%b, required 010", bus.ack); end
    bus.req = 3'b000;
    wait_xfer(100, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      failures++;
      $display("FAIL rst_new_xfer ok=%b left=%0d, required 1/0", ok, exp_q.size());
    end
  endtask

`ifdef PLOT_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int c0 = 0;
    done_delay = 0;
    set_bundle(0, 1, 2, 3, 4, 5, 5, 1'b0);
    push_exp(1, 2, 5, 5, 3'b000, 2'd0);
    bus.req = 3'b001;
    @(negedge clk);
    bus.req = 3'b000;
    if (bus.plot_start === 1'b1) c0 = cyc;
    wait_xfer(300, ok);
    checks++;
    if (!ok || bus.timeout_err !== 1'b1 || cyc - c0 != 100) begin
      failures++;
      $display("FAIL timeout ok=%b err=%b delay=%0d, required 1/1/100", ok, bus.timeout_err, cyc - c0);
    end
    @(negedge clk);
    checks++;
    if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pulse err=%b busy=%b, required 0/0", bus.timeout_err, bus.busy);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    bus.req        = 3'b000;
    bus.new_x_bus  = '0;
    bus.new_y_bus  = '0;
    bus.old_x_bus  = '0;
    bus.old_y_bus  = '0;
    bus.size_x_bus = '0;
    bus.size_y_bus = '0;
    bus.erase_only = 3'b000;
    bus.plot_done  = 1'b0;
    test_reset();
    test_single_ball();
    test_brick_erase();
    test_contention();
    test_zero_unchanged();
    test_reset_mid();
`ifdef PLOT_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
